// File: rtl/mem_req_issuer_if.sv
// Bundle of pipeline request, memory bus and writeback signals around mem_req_issuer.
// The master side is the issuer; the slave side is the pipeline/memory environment.
interface mem_req_issuer_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 32,
  parameter int CREG_ID_BITS = 4,
  parameter int DEST_BITS    = 5
);
  logic                    req_valid;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [LINE_WIDTH-1:0]   req_data;
  logic [DEST_BITS-1:0]    req_dest;
  logic                    req_ready;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [LINE_WIDTH-1:0]   mem_data;
  logic                    mem_rw;
  logic                    mem_valid;
  logic [CREG_ID_BITS-1:0] mem_id;
  logic                    mem_stall;

  logic                    mem_ready_in;
  logic [CREG_ID_BITS-1:0] mem_id_in;
  logic [LINE_WIDTH-1:0]   mem_data_in;

  logic                    wb_valid;
  logic [DEST_BITS-1:0]    wb_dest;
  logic [LINE_WIDTH-1:0]   wb_data;
  logic [CREG_ID_BITS:0]   outstanding;
  logic                    err_unexpected;

  modport master (
    input  req_valid, req_rw, req_addr, req_data, req_dest,
    input  mem_stall, mem_ready_in, mem_id_in, mem_data_in,
    output req_ready, mem_addr, mem_data, mem_rw, mem_valid, mem_id,
    output wb_valid, wb_dest, wb_data, outstanding, err_unexpected
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data, req_dest,
    output mem_stall, mem_ready_in, mem_id_in, mem_data_in,
    input  req_ready, mem_addr, mem_data, mem_rw, mem_valid, mem_id,
    input  wb_valid, wb_dest, wb_data, outstanding, err_unexpected
  );
endinterface

// File: rtl/mem_req_issuer.sv
// Issues tagged load/store requests to memory, tracks pending load tags and
// routes tagged load responses back to their destination register.
module mem_req_issuer #(
  parameter int CREG_ID_BITS = 4,
  parameter int DEST_BITS    = 5
) (
  input logic                clk,
  input logic                reset,
  mem_req_issuer_if.master   bus
);
  localparam int NTAGS = 1 << CREG_ID_BITS;

  logic [NTAGS-1:0]        pending;
  logic [DEST_BITS-1:0]    dest_table [NTAGS];
  logic [CREG_ID_BITS-1:0] free_tag;
  logic                    free_any;
  logic                    accept;
  logic                    load_accept;
  logic                    resp_hit;
  logic                    resp_miss;

  // Lowest free tag, taken from the registered bitmap so a tag freed this
  // cycle only becomes allocatable on the next one.
  always_comb begin
    free_tag = '0;
    free_any = 1'b0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!pending[i]) begin
        free_tag = CREG_ID_BITS'(i);
        free_any = 1'b1;
      end
    end
  end

  assign bus.req_ready = !reset && (!bus.mem_valid || !bus.mem_stall) && (bus.req_rw || free_any);
  assign accept        = bus.req_valid && bus.req_ready;
  assign load_accept   = accept && !bus.req_rw;
  assign resp_hit      = bus.mem_ready_in && pending[bus.mem_id_in];
  assign resp_miss     = bus.mem_ready_in && !pending[bus.mem_id_in];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_data       <= '0;
      bus.mem_rw         <= 1'b0;
      bus.mem_id         <= '0;
      bus.wb_valid       <= 1'b0;
      bus.wb_dest        <= '0;
      bus.wb_data        <= '0;
      bus.outstanding    <= '0;
      bus.err_unexpected <= 1'b0;
      pending            <= '0;
      for (int i = 0; i < NTAGS; i++) dest_table[i] <= '0;
    end else begin
      if (accept) begin
        bus.mem_valid <= 1'b1;
        bus.mem_addr  <= bus.req_addr;
        bus.mem_data  <= bus.req_data;
        bus.mem_rw    <= bus.req_rw;
        bus.mem_id    <= bus.req_rw ? '0 : free_tag;
      end else if (bus.mem_valid && !bus.mem_stall) begin
        bus.mem_valid <= 1'b0;
      end

      // A hit tag is pending, so it can never equal free_tag in the same cycle.
      if (load_accept) begin
        pending[free_tag]    <= 1'b1;
        dest_table[free_tag] <= bus.req_dest;
      end
      if (resp_hit) begin
        pending[bus.mem_id_in] <= 1'b0;
        bus.wb_dest            <= dest_table[bus.mem_id_in];
        bus.wb_data            <= bus.mem_data_in;
      end
      bus.wb_valid <= resp_hit;

      if (resp_miss) bus.err_unexpected <= 1'b1;

      case ({load_accept, resp_hit})
        2'b10:   bus.outstanding <= bus.outstanding + 1'b1;
        2'b01:   bus.outstanding <= bus.outstanding - 1'b1;
        default: bus.outstanding <= bus.outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_issuer.sv
// Directed bench for mem_req_issuer; load writebacks are matched against a
// scoreboard queue filled when each response is driven.
module tb_mem_req_issuer;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int IB = 4;
  localparam int DB = 5;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [DB+LW-1:0] sb [$];

  mem_req_issuer_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CREG_ID_BITS(IB), .DEST_BITS(DB)) bus ();

  mem_req_issuer #(.CREG_ID_BITS(IB), .DEST_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic valid, input logic rw, input logic [AW-1:0] addr,
                               input logic [LW-1:0] data, input logic [DB-1:0] dest);
    bus.req_valid = valid;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_dest  = dest;
    #1;
  endtask

  task automatic setResponse(input logic valid, input logic [IB-1:0] id, input logic [LW-1:0] data);
    bus.mem_ready_in = valid;
    bus.mem_id_in    = id;
    bus.mem_data_in  = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkDrained(input string tag);
    @(negedge clk);
    #1;
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  // Every writeback pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
        else begin
          errors++;
          $error("[TB] FAIL wb_spurious: observed wb_valid=1 dest=%0d data=%0h, expected no writeback",
                 bus.wb_dest, bus.wb_data);
        end
      if (sb.size() != 0) begin
        logic [DB+LW-1:0] exp;
        exp = sb.pop_front();
        checks++;
        assert ({bus.wb_dest, bus.wb_data} === exp)
          else begin
            errors++;
            $error("[TB] FAIL wb_match: observed dest=%0d data=%0h expected dest=%0d data=%0h",
                   bus.wb_dest, bus.wb_data, exp[DB+LW-1:LW], exp[LW-1:0]);
          end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.mem_stall = 1'b0;
    setResponse(1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();

    checkOutput("rst_mem_valid", bus.mem_valid, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_data", bus.mem_data, 0);
    checkOutput("rst_mem_rw", bus.mem_rw, 0);
    checkOutput("rst_mem_id", bus.mem_id, 0);
    checkOutput("rst_wb_valid", bus.wb_valid, 0);
    checkOutput("rst_wb_dest", bus.wb_dest, 0);
    checkOutput("rst_wb_data", bus.wb_data, 0);
    checkOutput("rst_outstanding", bus.outstanding, 0);
    checkOutput("rst_err", bus.err_unexpected, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);

    reset = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", bus.req_ready, 1);

    // Single load and its response
    applyStimulus(1'b1, 1'b0, 32'h100, '0, 5'd7);
    checkOutput("ld1_req_ready", bus.req_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("ld1_mem_valid", bus.mem_valid, 1);
    checkOutput("ld1_mem_rw", bus.mem_rw, 0);
    checkOutput("ld1_mem_id", bus.mem_id, 0);
    checkOutput("ld1_mem_addr", bus.mem_addr, 32'h100);
    checkOutput("ld1_outstanding", bus.outstanding, 1);
    setResponse(1'b1, 4'd0, 32'hDEADBEEF);
    sb.push_back({5'd7, 32'hDEADBEEF});
    tick();
    setResponse(1'b0, '0, '0);
    checkOutput("ld1_wb_valid", bus.wb_valid, 1);
    checkOutput("ld1_outstanding_after", bus.outstanding, 0);
    checkOutput("ld1_mem_valid_drop", bus.mem_valid, 0);
    checkDrained("ld1_drained");

    // Tag exhaustion
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i * 4), '0, 5'(i + 1));
      checkOutput($sformatf("exh_ready_%0d", i), bus.req_ready, 1);
      tick();
      checkOutput($sformatf("exh_tag_%0d", i), bus.mem_id, 64'(i));
    end
    checkOutput("exh_outstanding", bus.outstanding, 16);
    applyStimulus(1'b1, 1'b0, 32'h2FC, '0, 5'd30);
    checkOutput("exh_ld17_ready", bus.req_ready, 0);
    tick();
    checkOutput("exh_ld17_mem_valid", bus.mem_valid, 0);
    checkOutput("exh_ld17_outstanding", bus.outstanding, 16);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'hCAFE, '0);
    checkOutput("exh_st_ready", bus.req_ready, 1);
    tick();
    checkOutput("exh_st_mem_valid", bus.mem_valid, 1);
    checkOutput("exh_st_mem_rw", bus.mem_rw, 1);
    checkOutput("exh_st_mem_id", bus.mem_id, 0);
    checkOutput("exh_st_mem_data", bus.mem_data, 32'hCAFE);

    applyStimulus(1'b1, 1'b0, 32'h700, '0, 5'd20);
    setResponse(1'b1, 4'd5, 32'h5555);
    sb.push_back({5'd6, 32'h5555});
    checkOutput("reuse_ready_before", bus.req_ready, 0);
    tick();
    setResponse(1'b0, '0, '0);
    #1;
    checkOutput("reuse_outstanding_15", bus.outstanding, 15);
    checkOutput("reuse_ready_after", bus.req_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("reuse_tag5", bus.mem_id, 5);
    checkOutput("reuse_outstanding_16", bus.outstanding, 16);

    for (int i = 0; i < 16; i++) begin
      setResponse(1'b1, 4'(i), 32'h1000 + 32'(i));
      sb.push_back({(i == 5) ? 5'd20 : 5'(i + 1), 32'h1000 + 32'(i)});
      tick();
    end
    setResponse(1'b0, '0, '0);
    tick();
    checkOutput("drain_outstanding", bus.outstanding, 0);
    checkOutput("drain_err", bus.err_unexpected, 0);
    checkDrained("drain_sb");

    // Stall holds the bus stable
    applyStimulus(1'b1, 1'b1, 32'h400, 32'hAAAA, '0);
    tick();
    bus.mem_stall = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h404, '0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall_ready_%0d", i), bus.req_ready, 0);
      tick();
      checkOutput($sformatf("stall_valid_%0d", i), bus.mem_valid, 1);
      checkOutput($sformatf("stall_addr_%0d", i), bus.mem_addr, 32'h400);
      checkOutput($sformatf("stall_rw_%0d", i), bus.mem_rw, 1);
      checkOutput($sformatf("stall_data_%0d", i), bus.mem_data, 32'hAAAA);
    end
    bus.mem_stall = 1'b0;
    #1;
    checkOutput("unstall_ready", bus.req_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("unstall_rw", bus.mem_rw, 0);
    checkOutput("unstall_addr", bus.mem_addr, 32'h404);
    checkOutput("unstall_id", bus.mem_id, 0);
    checkOutput("unstall_outstanding", bus.outstanding, 1);
    setResponse(1'b1, 4'd0, 32'h9999);
    sb.push_back({5'd9, 32'h9999});
    tick();
    setResponse(1'b0, '0, '0);
    tick();
    checkOutput("unstall_outstanding_0", bus.outstanding, 0);
    checkDrained("unstall_sb");

    // Unexpected response
    setResponse(1'b1, 4'd3, 32'h3333);
    tick();
    setResponse(1'b0, '0, '0);
    checkOutput("unexp_err", bus.err_unexpected, 1);
    checkOutput("unexp_wb_valid", bus.wb_valid, 0);
    tick();
    tick();
    checkOutput("unexp_err_sticky", bus.err_unexpected, 1);
    checkDrained("unexp_sb");

    // Same-cycle allocate and free
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h500 + 32'(i * 4), '0, 5'(10 + i));
      tick();
      checkOutput($sformatf("same_tag_%0d", i), bus.mem_id, 64'(i));
    end
    checkOutput("same_outstanding_4", bus.outstanding, 4);
    applyStimulus(1'b1, 1'b0, 32'h600, '0, 5'd14);
    setResponse(1'b1, 4'd2, 32'h2222);
    sb.push_back({5'd12, 32'h2222});
    checkOutput("same_ready", bus.req_ready, 1);
    tick();
    setResponse(1'b0, '0, '0);
    checkOutput("same_outstanding_hold", bus.outstanding, 4);
    checkOutput("same_new_tag", bus.mem_id, 4);
    applyStimulus(1'b1, 1'b0, 32'h604, '0, 5'd15);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("same_reused_tag2", bus.mem_id, 2);
    checkOutput("same_outstanding_5", bus.outstanding, 5);
    setResponse(1'b1, 4'd4, 32'h4444);
    sb.push_back({5'd14, 32'h4444});
    tick();
    setResponse(1'b0, '0, '0);
    checkOutput("pre_rst_outstanding", bus.outstanding, 4);
    checkDrained("same_sb");

    // Reset with loads outstanding
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_mem_valid", bus.mem_valid, 0);
    checkOutput("mid_rst_mem_addr", bus.mem_addr, 0);
    checkOutput("mid_rst_mem_id", bus.mem_id, 0);
    checkOutput("mid_rst_wb_dest", bus.wb_dest, 0);
    checkOutput("mid_rst_wb_data", bus.wb_data, 0);
    checkOutput("mid_rst_outstanding", bus.outstanding, 0);
    checkOutput("mid_rst_err", bus.err_unexpected, 0);
    checkOutput("mid_rst_req_ready", bus.req_ready, 0);
    tick();
    reset = 1'b0;
    setResponse(1'b1, 4'd1, 32'h1111);
    tick();
    setResponse(1'b0, '0, '0);
    checkOutput("post_rst_err", bus.err_unexpected, 1);
    checkOutput("post_rst_wb_valid", bus.wb_valid, 0);
    checkOutput("post_rst_outstanding", bus.outstanding, 0);
    checkDrained("post_rst_sb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
